// File: rtl/lin_adder_arb.sv
// Round-robin arbiter sharing one combinational adder between two
// requesters, with operand hold time and a registered result.
module lin_adder_arb #(
  parameter int NBIT    = 8,
  parameter int ADD_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [NBIT-1:0]  req0_a,
  input  logic [NBIT-1:0]  req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [NBIT-1:0]  req1_a,
  input  logic [NBIT-1:0]  req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [NBIT-1:0]  rsp_s,
  output logic [NBIT-1:0]  add_a,
  output logic [NBIT-1:0]  add_b,
  input  logic [NBIT-1:0]  add_s,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int LW = 4;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             owner_q, owner_d;
  logic [NBIT-1:0]  op_a_q, op_a_d;
  logic [NBIT-1:0]  op_b_q, op_b_d;
  logic [NBIT-1:0]  rsp_s_q, rsp_s_d;
  logic [1:0]       rsp_v_q, rsp_v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LW-1:0]    lat_q, lat_d;

  logic [1:0] req_v;
  logic       gnt_vld;
  logic       gnt;
  logic       rsp_hs;

  assign req_v = {req1_valid, req0_valid};

  // Grant: pointer side first, then the other side.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = ptr_q;
    if (req_v[ptr_q]) begin
      gnt_vld = 1'b1;
      gnt     = ptr_q;
    end else if (req_v[~ptr_q]) begin
      gnt_vld = 1'b1;
      gnt     = ~ptr_q;
    end
  end

  assign rsp_hs = owner_q ? rsp1_ready : rsp0_ready;

  // Next state, datapath updates and request readies.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    rsp_s_d    = rsp_s_q;
    rsp_v_d    = rsp_v_q;
    cnt_d      = cnt_q;
    lat_d      = lat_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          req0_ready = ~gnt;
          req1_ready = gnt;
          op_a_d     = gnt ? req1_a : req0_a;
          op_b_d     = gnt ? req1_b : req0_b;
          owner_d    = gnt;
          lat_d      = LW'(ADD_LAT - 1);
          state_d    = EXEC;
        end
      end
      EXEC: begin
        if (lat_q == '0) begin
          rsp_s_d          = add_s;
          rsp_v_d[owner_q] = 1'b1;
          state_d          = RESP;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_hs) begin
          rsp_v_d = '0;
          ptr_d   = ~owner_q;
          cnt_d   = cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      rsp_s_q <= '0;
      rsp_v_q <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      rsp_s_q <= rsp_s_d;
      rsp_v_q <= rsp_v_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
    end
  end

  assign add_a      = op_a_q;
  assign add_b      = op_b_q;
  assign rsp_s      = rsp_s_q;
  assign rsp0_valid = rsp_v_q[0];
  assign rsp1_valid = rsp_v_q[1];
  assign busy       = (state_q != IDLE);
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_lin_adder_arb.sv
// Scoreboard bench for lin_adder_arb with a behavioural adder
// on the add_a/add_b/add_s port.
module tb_lin_adder_arb;

  localparam int NBIT    = 8;
  localparam int ADD_LAT = 3;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready;
  logic [NBIT-1:0]  req0_a, req0_b;
  logic             req1_valid, req1_ready;
  logic [NBIT-1:0]  req1_a, req1_b;
  logic             rsp0_valid, rsp0_ready;
  logic             rsp1_valid, rsp1_ready;
  logic [NBIT-1:0]  rsp_s, add_a, add_b, add_s;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  typedef struct {
    int             r;
    logic [NBIT-1:0] s;
  } exp_t;

  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  always #5 clk = ~clk;

  assign add_s = add_a + add_b;

  lin_adder_arb #(
    .NBIT(NBIT), .ADD_LAT(ADD_LAT), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_s(rsp_s), .add_a(add_a), .add_b(add_b), .add_s(add_s),
    .busy(busy), .op_count(op_count)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    exp_cnt = '0;
  endtask

  // One request on requester r; stall = cycles rsp_ready is held low.
  task automatic do_op(input int r, input logic [7:0] a,
                       input logic [7:0] b, input int stall);
    int n;
    bit got;
    exp_t e;
    logic [7:0] s_hold;
    logic [1:0] vexp;
    @(negedge clk);
    if (r == 0) begin
      req0_valid = 1; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1; req1_a = a; req1_b = b;
    end
    #1;
    n = 0;
    while (!(r == 0 ? req0_ready : req1_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL req_ready_timeout r=%0d got=0 want=1", r);
      req0_valid = 0; req1_valid = 0;
      return;
    end
    checks++;
    if ((r == 0 ? req1_ready : req0_ready) !== 1'b0) begin
      errors++;
      $display("FAIL other_ready r=%0d got=1 want=0", r);
    end
    q.push_back('{r, a + b});
    @(posedge clk);
    n = 0; got = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      req0_valid = 0; req1_valid = 0;
      if (rsp0_valid | rsp1_valid) got = 1;
      else begin
        checks++;
        if (add_a !== a || add_b !== b || busy !== 1'b1) begin
          errors++;
          $display("FAIL exec_hold got=%h/%h busy=%b want=%h/%h busy=1",
                   add_a, add_b, busy, a, b);
        end
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL rsp_timeout r=%0d got=none want=rsp_valid", r);
      return;
    end
    checks++;
    if (n !== ADD_LAT + 1) begin
      errors++;
      $display("FAIL latency got=%0d want=%0d", n, ADD_LAT + 1);
    end
    e = q.pop_front();
    vexp = (e.r == 1) ? 2'b10 : 2'b01;
    checks++;
    if ({rsp1_valid, rsp0_valid} !== vexp) begin
      errors++;
      $display("FAIL rsp_owner got=%b want=%b",
               {rsp1_valid, rsp0_valid}, vexp);
    end
    checks++;
    if (rsp_s !== e.s) begin
      errors++;
      $display("FAIL rsp_sum a=%h b=%h got=%h want=%h", a, b, rsp_s, e.s);
    end
    s_hold = e.s;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (r == 0) begin
        req1_valid = 1; req1_a = 8'h11; req1_b = 8'h22; rsp1_ready = 1;
      end else begin
        req0_valid = 1; req0_a = 8'h11; req0_b = 8'h22; rsp0_ready = 1;
      end
      #1;
      checks++;
      if ({rsp1_valid, rsp0_valid} !== vexp || rsp_s !== s_hold ||
          busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall v=%b s=%h busy=%b rdy=%b%b want v=%b s=%h busy=1 rdy=00",
                 {rsp1_valid, rsp0_valid}, rsp_s, busy, req1_ready,
                 req0_ready, vexp, s_hold);
      end
    end
    if (r == 0) rsp0_ready = 1; else rsp1_ready = 1;
    @(posedge clk);
    @(negedge clk);
    rsp0_ready = 0; rsp1_ready = 0;
    req0_valid = 0; req1_valid = 0;
    exp_cnt++;
    checks++;
    if ({rsp1_valid, rsp0_valid} !== 2'b00 || op_count !== exp_cnt ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL complete v=%b cnt=%0d busy=%b want v=00 cnt=%0d busy=0",
               {rsp1_valid, rsp0_valid}, op_count, busy, exp_cnt);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if (busy !== 0 || rsp0_valid !== 0 || rsp1_valid !== 0 ||
        add_a !== 0 || add_b !== 0 || rsp_s !== 0 || op_count !== 0 ||
        req0_ready !== 0 || req1_ready !== 0) begin
      errors++;
      $display("FAIL reset busy=%b v=%b%b a=%h b=%h s=%h cnt=%0d rdy=%b%b want all 0",
               busy, rsp1_valid, rsp0_valid, add_a, add_b, rsp_s,
               op_count, req1_ready, req0_ready);
    end
  endtask

  task automatic test_single();
    do_op(0, 8'h35, 8'h4A, 0);
    do_op(1, 8'hFF, 8'h01, 0);
    do_op(1, 8'h80, 8'h80, 0);
    do_op(1, 8'hAA, 8'h55, 0);
    do_op(0, 8'h00, 8'h00, 0);
    do_op(0, 8'hFF, 8'hFF, 0);
  endtask

  task automatic test_stall();
    do_op(0, 8'h12, 8'h34, 5);
    do_op(1, 8'hF0, 8'h0F, 3);
  endtask

  task automatic test_alternate();
    logic [7:0] a0[4] = '{8'h01, 8'h10, 8'h7F, 8'hC3};
    logic [7:0] b0[4] = '{8'h02, 8'h20, 8'h01, 8'h3C};
    logic [7:0] a1[4] = '{8'h99, 8'hFE, 8'h00, 8'h5A};
    logic [7:0] b1[4] = '{8'h66, 8'h03, 8'hFF, 8'hA5};
    int i0, i1, g, eg, n;
    exp_t e;
    apply_reset();
    i0 = 0; i1 = 0; eg = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      rsp0_ready = 1; rsp1_ready = 1;
      req0_valid = (i0 < 4); req1_valid = (i1 < 4);
      req0_a = a0[i0 & 3]; req0_b = b0[i0 & 3];
      req1_a = a1[i1 & 3]; req1_b = b1[i1 & 3];
      #1;
      if (req0_ready && !req1_ready) g = 0;
      else if (req1_ready && !req0_ready) g = 1;
      else g = -1;
      checks++;
      if (g !== eg) begin
        errors++;
        $display("FAIL alt_grant k=%0d got=%0d want=%0d", k, g, eg);
        break;
      end
      if (g == 0) q.push_back('{0, a0[i0] + b0[i0]});
      else q.push_back('{1, a1[i1] + b1[i1]});
      @(posedge clk);
      if (g == 0) i0++; else i1++;
      n = 0;
      do begin
        @(negedge clk); n++;
      end while (!(rsp0_valid | rsp1_valid) && n < 40);
      checks++;
      if (!(rsp0_valid | rsp1_valid)) begin
        errors++;
        $display("FAIL alt_timeout k=%0d got=none want=rsp_valid", k);
        break;
      end
      e = q.pop_front();
      checks++;
      if ({rsp1_valid, rsp0_valid} !== (e.r == 1 ? 2'b10 : 2'b01) ||
          rsp_s !== e.s) begin
        errors++;
        $display("FAIL alt_rsp k=%0d got v=%b s=%h want r=%0d s=%h",
                 k, {rsp1_valid, rsp0_valid}, rsp_s, e.r, e.s);
      end
      exp_cnt++;
      eg = 1 - eg;
    end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    checks++;
    if (op_count !== exp_cnt || exp_cnt !== 16'd8) begin
      errors++;
      $display("FAIL alt_count got=%0d want=8", op_count);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] a, b;
    for (int i = 0; i < 150; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      do_op(int'($urandom_range(0, 1)), a, b, 0);
    end
  endtask

  // Reset pulse with the FSM at stage st (1=EXEC, 2=RESP).
  task automatic reset_in(input int st);
    int n;
    do_op(0, 8'h21, 8'h43, 0);
    @(negedge clk);
    req0_valid = 1; req0_a = 8'h5C; req0_b = 8'h0D;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 0;
    if (st == 2) begin
      n = 0;
      while (!rsp0_valid && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (!rsp0_valid) begin
        errors++;
        $display("FAIL rst_resp_reach got=0 want=1");
      end
    end
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    exp_cnt = '0;
    #1;
    checks++;
    if (rsp0_valid !== 0 || rsp1_valid !== 0 || add_a !== 0 ||
        add_b !== 0 || op_count !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL mid_reset st=%0d v=%b%b a=%h b=%h cnt=%0d busy=%b want all 0",
               st, rsp1_valid, rsp0_valid, add_a, add_b, op_count, busy);
    end
    req0_valid = 1; req1_valid = 1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ptr st=%0d got rdy=%b%b want 01",
               st, req1_ready, req0_ready);
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_reset_mid();
    reset_in(1);
    reset_in(2);
    do_op(1, 8'h7E, 8'h81, 0);
  endtask

  initial begin
    rst = 1;
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    test_reset();
    test_single();
    test_stall();
    test_alternate();
    test_sweep();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
